// File: rtl/corner_tracker_pkg.sv
// Shared types and constants for the corner tracker.
// Corner addresses travel through this package in a wide container struct;
// modules narrow each field to their own ROW_W/COL_W (both must be <= 16).
package corner_tracker_pkg;

    localparam int FIELD_W = 16;

    typedef struct packed {
        logic [FIELD_W-1:0] row;
        logic [FIELD_W-1:0] col;
    } corner_addr_t;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_LOCK   = 2'd1,
        ST_HOLD   = 2'd2
    } track_state_t;

    localparam int CORNER_UL = 0;
    localparam int CORNER_UR = 1;
    localparam int CORNER_DL = 2;
    localparam int CORNER_DR = 3;

    // Default (no detection) corner: the frame's own corners.
    function automatic corner_addr_t default_corner(input int idx, input int h_res, input int v_res);
        corner_addr_t c;
        c.row = (idx == CORNER_DL || idx == CORNER_DR) ? FIELD_W'(v_res - 1) : '0;
        c.col = (idx == CORNER_UR || idx == CORNER_DR) ? FIELD_W'(h_res - 1) : '0;
        return c;
    endfunction

endpackage

// File: rtl/corner_tracker_extreme_accum.sv
// Per-frame extreme-pixel accumulator: topmost (U), bottommost (D),
// leftmost (L) and rightmost (R) set pixels plus a saturating set-pixel count.
// The *_next outputs already include the pixel presented this cycle, so the
// caller can publish a frame result on the cycle its last pixel is accepted.
module extreme_accum
    import corner_tracker_pkg::*;
#(
    parameter  int ROW_W  = 10,
    parameter  int COL_W  = 10,
    parameter  int CNT_W  = 20,
    localparam int ADDR_W = ROW_W + COL_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_accept,
    input  logic              i_seed,
    input  logic [ROW_W-1:0]  i_row,
    input  logic [COL_W-1:0]  i_col,
    input  logic              i_data,
    output logic [ADDR_W-1:0] o_u_next,
    output logic [ADDR_W-1:0] o_d_next,
    output logic [ADDR_W-1:0] o_l_next,
    output logic [ADDR_W-1:0] o_r_next,
    output logic [CNT_W-1:0]  o_count_next
);

    logic [ADDR_W-1:0] u_reg, d_reg, l_reg, r_reg;
    logic [ADDR_W-1:0] u_next, d_next, l_next, r_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              any_reg, any_next;
    logic [ADDR_W-1:0] pos;

    assign pos = {i_row, i_col};

    // Update extremes; the first set pixel of a frame initialises all four.
    always_comb begin
        u_next     = u_reg;
        d_next     = d_reg;
        l_next     = l_reg;
        r_next     = r_reg;
        any_next   = any_reg;
        count_next = count_reg;
        if (i_accept) begin
            if (i_seed) begin
                any_next   = i_data;
                u_next     = pos;
                d_next     = pos;
                l_next     = pos;
                r_next     = pos;
                count_next = i_data ? CNT_W'(1) : '0;
            end else if (i_data) begin
                any_next = 1'b1;
                if (!any_reg) begin
                    u_next = pos;
                    d_next = pos;
                    l_next = pos;
                    r_next = pos;
                end else begin
                    if (i_row <  u_reg[ADDR_W-1:COL_W]) u_next = pos;
                    if (i_row >= d_reg[ADDR_W-1:COL_W]) d_next = pos;
                    if (i_col <= l_reg[COL_W-1:0])      l_next = pos;
                    if (i_col >  r_reg[COL_W-1:0])      r_next = pos;
                end
                if (count_reg != '1) count_next = count_reg + CNT_W'(1);
            end
        end
    end

    // Accumulator state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            u_reg     <= '0;
            d_reg     <= '0;
            l_reg     <= '0;
            r_reg     <= '0;
            any_reg   <= 1'b0;
            count_reg <= '0;
        end else begin
            u_reg     <= u_next;
            d_reg     <= d_next;
            l_reg     <= l_next;
            r_reg     <= r_next;
            any_reg   <= any_next;
            count_reg <= count_next;
        end
    end

    assign o_u_next     = u_next;
    assign o_d_next     = d_next;
    assign o_l_next     = l_next;
    assign o_r_next     = r_next;
    assign o_count_next = count_next;

endmodule

// File: rtl/corner_tracker.sv
// Corner tracker top: raster position, frame-end detection, SEARCH/LOCK/HOLD
// state machine and registered corner outputs.
// Optional macro CORNER_TRACKER_SMOOTH_EN: while locked or holding, a good
// frame publishes the rounded average of old and new coordinates.
module corner_tracker
    import corner_tracker_pkg::*;
#(
    parameter  int H_RES       = 800,
    parameter  int V_RES       = 600,
    parameter  int MIN_PIXELS  = 255,
    parameter  int CNT_W       = 20,
    parameter  int HOLD_FRAMES = 4,
    localparam int ROW_W       = $clog2(V_RES),
    localparam int COL_W       = $clog2(H_RES),
    localparam int ADDR_W      = ROW_W + COL_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic              i_data,
    input  logic              i_sof,
    output logic              o_valid,
    output logic              o_success,
    output logic              o_held,
    output logic [ADDR_W-1:0] o_ul_addr,
    output logic [ADDR_W-1:0] o_ur_addr,
    output logic [ADDR_W-1:0] o_dl_addr,
    output logic [ADDR_W-1:0] o_dr_addr,
    output logic [CNT_W-1:0]  o_pix_count
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_RES - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_RES - 1);
    localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_PIXELS);
    localparam int               FC_W     = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [FC_W-1:0]  HOLD_MAX = FC_W'(HOLD_FRAMES);

    logic [ROW_W-1:0] row_reg, row_next, eff_row;
    logic [COL_W-1:0] col_reg, col_next, eff_col;
    logic             seed, frame_end;

    // i_sof relocates the current pixel to (0,0); otherwise use the raster counters.
    always_comb begin
        eff_row  = i_sof ? '0 : row_reg;
        eff_col  = i_sof ? '0 : col_reg;
        row_next = row_reg;
        col_next = col_reg;
        if (i_valid) begin
            if (eff_col == COL_LAST) begin
                col_next = '0;
                row_next = (eff_row == ROW_LAST) ? '0 : eff_row + ROW_W'(1);
            end else begin
                col_next = eff_col + COL_W'(1);
                row_next = eff_row;
            end
        end
    end

    assign seed      = (eff_row == '0) && (eff_col == '0);
    assign frame_end = i_valid && (eff_row == ROW_LAST) && (eff_col == COL_LAST);

    // Raster position counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            row_reg <= '0;
            col_reg <= '0;
        end else begin
            row_reg <= row_next;
            col_reg <= col_next;
        end
    end

    logic [ADDR_W-1:0] u_next, d_next, l_next, r_next;
    logic [CNT_W-1:0]  count_next;

    extreme_accum #(
        .ROW_W (ROW_W),
        .COL_W (COL_W),
        .CNT_W (CNT_W)
    ) u_accum (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_accept     (i_valid),
        .i_seed       (seed),
        .i_row        (eff_row),
        .i_col        (eff_col),
        .i_data       (i_data),
        .o_u_next     (u_next),
        .o_d_next     (d_next),
        .o_l_next     (l_next),
        .o_r_next     (r_next),
        .o_count_next (count_next)
    );

    logic success;
    assign success = (count_next >= MIN_CNT);

    track_state_t    state_reg, state_next;
    logic [FC_W-1:0] fail_cnt_reg, fail_cnt_next;
    logic            held_reg, held_next;
    logic            publish, go_default;

    // Frame-end state machine; decides publish / keep / fall back to defaults.
    always_comb begin
        state_next    = state_reg;
        fail_cnt_next = fail_cnt_reg;
        held_next     = held_reg;
        publish       = 1'b0;
        go_default    = 1'b0;
        if (frame_end) begin
            if (success) begin
                state_next    = ST_LOCK;
                fail_cnt_next = '0;
                held_next     = 1'b0;
                publish       = 1'b1;
            end else begin
                case (state_reg)
                    ST_LOCK: begin
                        if (HOLD_FRAMES == 0) begin
                            state_next = ST_SEARCH;
                            held_next  = 1'b0;
                            go_default = 1'b1;
                        end else begin
                            state_next    = ST_HOLD;
                            fail_cnt_next = FC_W'(1);
                            held_next     = 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (fail_cnt_reg < HOLD_MAX) begin
                            fail_cnt_next = fail_cnt_reg + FC_W'(1);
                            held_next     = 1'b1;
                        end else begin
                            state_next    = ST_SEARCH;
                            fail_cnt_next = '0;
                            held_next     = 1'b0;
                            go_default    = 1'b1;
                        end
                    end
                    default: begin
                        state_next = ST_SEARCH;
                        held_next  = 1'b0;
                        go_default = 1'b1;
                    end
                endcase
            end
        end
    end

    logic [ADDR_W-1:0] corner_reg [4];
    logic [ADDR_W-1:0] raw_c      [4];
    logic [ADDR_W-1:0] dflt_c     [4];
    logic [ADDR_W-1:0] pub_c      [4];

    assign raw_c[CORNER_UL] = u_next;
    assign raw_c[CORNER_UR] = r_next;
    assign raw_c[CORNER_DL] = l_next;
    assign raw_c[CORNER_DR] = d_next;

`ifdef CORNER_TRACKER_SMOOTH_EN
    logic smooth_sel;
    assign smooth_sel = (state_reg != ST_SEARCH);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_corner
            localparam corner_addr_t DFLT = default_corner(gi, H_RES, V_RES);
            assign dflt_c[gi] = {DFLT.row[ROW_W-1:0], DFLT.col[COL_W-1:0]};
`ifdef CORNER_TRACKER_SMOOTH_EN
            logic [ROW_W:0] row_sum;
            logic [COL_W:0] col_sum;
            assign row_sum = {1'b0, corner_reg[gi][ADDR_W-1:COL_W]} + {1'b0, raw_c[gi][ADDR_W-1:COL_W]}
                             + (ROW_W + 1)'(1);
            assign col_sum = {1'b0, corner_reg[gi][COL_W-1:0]} + {1'b0, raw_c[gi][COL_W-1:0]}
                             + (COL_W + 1)'(1);
            assign pub_c[gi] = smooth_sel ? {row_sum[ROW_W:1], col_sum[COL_W:1]} : raw_c[gi];
`else
            assign pub_c[gi] = raw_c[gi];
`endif
        end
    endgenerate

    // FSM state and registered outputs, updated only when a frame completes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg     <= ST_SEARCH;
            fail_cnt_reg  <= '0;
            held_reg      <= 1'b0;
            o_valid       <= 1'b0;
            o_success     <= 1'b0;
            o_pix_count   <= '0;
            for (int i = 0; i < 4; i++) corner_reg[i] <= dflt_c[i];
        end else begin
            state_reg    <= state_next;
            fail_cnt_reg <= fail_cnt_next;
            held_reg     <= held_next;
            o_valid      <= frame_end;
            if (frame_end) begin
                o_success   <= success;
                o_pix_count <= count_next;
            end
            for (int i = 0; i < 4; i++) begin
                if (publish)         corner_reg[i] <= pub_c[i];
                else if (go_default) corner_reg[i] <= dflt_c[i];
            end
        end
    end

    assign o_held    = held_reg;
    assign o_ul_addr = corner_reg[CORNER_UL];
    assign o_ur_addr = corner_reg[CORNER_UR];
    assign o_dl_addr = corner_reg[CORNER_DL];
    assign o_dr_addr = corner_reg[CORNER_DR];

endmodule
